tmds_encoder_pipe: RTL and testbench

- Parametrised multi-channel TMDS encoder. Encodes NUM_CH lanes in lock-step, one 10-bit symbol per lane per clklow cycle.
- Modes: control period, TERC4 data island, DVI/HDMI video with running disparity, and video guard band.
- Fully pipelined, with a valid qualifier. Drives per-lane 10-bit words to the downstream serializer stage.

---
 rtl/tmds_encoder_pipe.sv | 195 +++++++++++++++++++
 tb/tb_tmds_encoder_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe: NUM_CH-lane TMDS encoder with a two-stage pipeline.
// Handles control, TERC4 data island, video (running disparity) and guard band.
// Optional macro TMDS_DISP_MON_EN exposes each lane's disparity counter on disp_mon.
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                      clklow,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [1:0]                mode,
  input  logic [8*NUM_CH-1:0]       pix_data,
  input  logic [2*NUM_CH-1:0]       ctrl,
  input  logic [4*NUM_CH-1:0]       aux_data,
  output logic [10*NUM_CH-1:0]      tmds_word,
  output logic                      out_valid
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [CNT_W*NUM_CH-1:0]   disp_mon
`endif
);

  localparam logic [9:0] CTRL00_WORD = 10'b1101010100;

  function automatic logic [3:0] countOnes(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + {3'b000, v[k]};
    return s;
  endfunction

  function automatic logic [8:0] encodeQm(input logic [7:0] d);
    logic [3:0] ones;
    logic       useXnor;
    logic [8:0] q;
    ones    = countOnes(d);
    useXnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q       = '0;
    q[0]    = d[0];
    for (int k = 1; k < 8; k++) q[k] = useXnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8]    = ~useXnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrlCode(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4Code(input logic [3:0] a);
    case (a)
      4'h0: return 10'b1010011100;
      4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;
      4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;
      4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;
      4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;
      4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;
      4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;
      4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  logic                validS1_q;
  logic [1:0]          modeS1_q;
  logic [8:0]          qmS1_d   [NUM_CH];
  logic [3:0]          n1S1_d   [NUM_CH];
  logic [8:0]          qmS1_q   [NUM_CH];
  logic [3:0]          n1S1_q   [NUM_CH];
  logic [1:0]          ctrlS1_q [NUM_CH];
  logic [3:0]          auxS1_q  [NUM_CH];

  logic                outValid_q;
  logic [9:0]          wordS2_d [NUM_CH];
  logic [9:0]          wordS2_q [NUM_CH];
  logic [CNT_W-1:0]    cntS2_d  [NUM_CH];
  logic [CNT_W-1:0]    cntS2_q  [NUM_CH];

  // Stage-1 transition-minimised byte and its ones count, per lane.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      qmS1_d[i] = encodeQm(pix_data[8*i +: 8]);
      n1S1_d[i] = countOnes(qmS1_d[i][7:0]);
    end
  end

  // Stage-1 register: valid is reset so bubbles and reset flush the pipe; payload just follows.
  always_ff @(posedge clklow) begin
    if (reset) validS1_q <= 1'b0;
    else       validS1_q <= in_valid;
    modeS1_q <= mode;
    for (int i = 0; i < NUM_CH; i++) begin
      qmS1_q[i]   <= qmS1_d[i];
      n1S1_q[i]   <= n1S1_d[i];
      ctrlS1_q[i] <= ctrl[2*i +: 2];
      auxS1_q[i]  <= aux_data[4*i +: 4];
    end
  end

  // Stage-2 symbol selection and disparity update; a bubble keeps word and counter.
  always_comb begin
    logic [8:0]       qm;
    logic [CNT_W-1:0] cnt, n1s, n0s, twoQm8, twoNotQm8;
    logic             cntZero, cntPos, cntNeg, balanced, moreOnes, moreZeros;
    for (int i = 0; i < NUM_CH; i++) begin
      wordS2_d[i] = wordS2_q[i];
      cntS2_d[i]  = cntS2_q[i];
      qm          = qmS1_q[i];
      cnt         = cntS2_q[i];
      n1s         = {{(CNT_W-4){1'b0}}, n1S1_q[i]};
      n0s         = CNT_W'(8) - n1s;
      twoQm8      = qm[8] ? CNT_W'(2) : '0;
      twoNotQm8   = qm[8] ? '0 : CNT_W'(2);
      cntZero     = (cnt == '0);
      cntNeg      = cnt[CNT_W-1];
      cntPos      = !cntNeg && !cntZero;
      balanced    = (n1S1_q[i] == 4'd4);
      moreOnes    = (n1S1_q[i] > 4'd4);
      moreZeros   = (n1S1_q[i] < 4'd4);
      if (validS1_q) begin
        case (modeS1_q)
          2'd0: begin
            wordS2_d[i] = ctrlCode(ctrlS1_q[i]);
            cntS2_d[i]  = '0;
          end
          2'd1: begin
            wordS2_d[i] = terc4Code(auxS1_q[i]);
            cntS2_d[i]  = '0;
          end
          2'd3: begin
            wordS2_d[i] = ((i % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
            cntS2_d[i]  = '0;
          end
          default: begin
            if (cntZero || balanced) begin
              wordS2_d[i] = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
              cntS2_d[i]  = qm[8] ? (cnt + n1s - n0s) : (cnt + n0s - n1s);
            end else if ((cntPos && moreOnes) || (cntNeg && moreZeros)) begin
              wordS2_d[i] = {1'b1, qm[8], ~qm[7:0]};
              cntS2_d[i]  = cnt + twoQm8 + n0s - n1s;
            end else begin
              wordS2_d[i] = {1'b0, qm[8], qm[7:0]};
              cntS2_d[i]  = cnt + n1s - n0s - twoNotQm8;
            end
          end
        endcase
      end
    end
  end

  // Stage-2 register: output word, output valid and per-lane disparity counters.
  always_ff @(posedge clklow) begin
    if (reset) begin
      outValid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        wordS2_q[i] <= CTRL00_WORD;
        cntS2_q[i]  <= '0;
      end
    end else begin
      outValid_q <= validS1_q;
      for (int i = 0; i < NUM_CH; i++) begin
        wordS2_q[i] <= wordS2_d[i];
        cntS2_q[i]  <= cntS2_d[i];
      end
    end
  end

  // Flatten the per-lane registers onto the output buses.
  always_comb begin
    tmds_word = '0;
    for (int i = 0; i < NUM_CH; i++) tmds_word[10*i +: 10] = wordS2_q[i];
  end

  assign out_valid = outValid_q;

`ifdef TMDS_DISP_MON_EN
  // Counter state after the symbol currently presented on tmds_word.
  always_comb begin
    disp_mon = '0;
    for (int i = 0; i < NUM_CH; i++) disp_mon[CNT_W*i +: CNT_W] = cntS2_q[i];
  end
`endif

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb_tmds_encoder_pipe: directed plus random stimulus for tmds_encoder_pipe.
// A behavioural model predicts each word when it is driven; results are checked
// from a scoreboard queue when they appear two cycles later.
module tb_tmds_encoder_pipe;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;
  localparam logic [10*NUM_CH-1:0] RESET_WORDS = {NUM_CH{10'b1101010100}};

  localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                          10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  typedef struct packed {
    logic [10*NUM_CH-1:0]    word;
    logic [CNT_W*NUM_CH-1:0] disp;
  } expect_t;

  logic                    clklow = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic [1:0]              mode;
  logic [8*NUM_CH-1:0]     pix_data;
  logic [2*NUM_CH-1:0]     ctrl;
  logic [4*NUM_CH-1:0]     aux_data;
  logic [10*NUM_CH-1:0]    tmds_word;
  logic                    out_valid;
`ifdef TMDS_DISP_MON_EN
  logic [CNT_W*NUM_CH-1:0] disp_mon;
`endif

  expect_t                 sb[$];
  int                      modelCnt [NUM_CH];
  logic [10*NUM_CH-1:0]    lastWord;
  logic [CNT_W*NUM_CH-1:0] lastDisp;
  logic                    hist1, hist2;
  int                      nCompared = 0;
  int                      nMismatched = 0;

  tmds_encoder_pipe #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clklow    (clklow),
    .reset     (reset),
    .in_valid  (in_valid),
    .mode      (mode),
    .pix_data  (pix_data),
    .ctrl      (ctrl),
    .aux_data  (aux_data),
    .tmds_word (tmds_word),
    .out_valid (out_valid)
`ifdef TMDS_DISP_MON_EN
    ,
    .disp_mon  (disp_mon)
`endif
  );

  // Pixel clock.
  always #5 clklow = ~clklow;

  // Reference video encoder for one lane, updating that lane's model counter.
  task automatic modelVideo(input int lane, input logic [7:0] d, output logic [9:0] w);
    int         n1d, n1, n0, q8;
    logic       useXnor;
    logic [8:0] qm;
    n1d     = $countones(d);
    useXnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm      = '0;
    qm[0]   = d[0];
    for (int k = 1; k < 8; k++) qm[k] = useXnor ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
    qm[8]   = !useXnor;
    q8      = qm[8] ? 1 : 0;
    n1      = $countones(qm[7:0]);
    n0      = 8 - n1;
    if (modelCnt[lane] == 0 || n1 == n0) begin
      w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      modelCnt[lane] += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((modelCnt[lane] > 0 && n1 > n0) || (modelCnt[lane] < 0 && n0 > n1)) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      modelCnt[lane] += 2 * q8 + (n0 - n1);
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      modelCnt[lane] += (n1 - n0) - 2 * (1 - q8);
    end
  endtask

  // Predict all lanes of one valid input word and push it to the scoreboard.
  task automatic pushExpect(input logic [1:0] m, input logic [8*NUM_CH-1:0] pd,
                            input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] a);
    expect_t    e;
    logic [9:0] w;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (m)
        2'd0: begin w = CTRL_TAB[c[2*i +: 2]]; modelCnt[i] = 0; end
        2'd1: begin w = TERC4_TAB[a[4*i +: 4]]; modelCnt[i] = 0; end
        2'd3: begin w = (i % 2 == 0) ? 10'b1011001100 : 10'b0100110011; modelCnt[i] = 0; end
        default: modelVideo(i, pd[8*i +: 8], w);
      endcase
      e.word[10*i +: 10]      = w;
      e.disp[CNT_W*i +: CNT_W] = CNT_W'(modelCnt[i]);
    end
    sb.push_back(e);
  endtask

  // Compare out_valid, the held/new word and the disparity monitor at mid-cycle.
  task automatic checkOutput(input logic expV);
    expect_t e;
    nCompared++;
    assert (out_valid === expV) else begin
      nMismatched++;
      $error("FAIL out_valid: got %b expected %b", out_valid, expV);
    end
    if (expV) begin
      nCompared++;
      assert (sb.size() > 0) else begin
        nMismatched++;
        $error("FAIL scoreboard_underflow: got size %0d expected >0", sb.size());
      end
      if (sb.size() > 0) begin
        e        = sb.pop_front();
        lastWord = e.word;
        lastDisp = e.disp;
      end
    end
    nCompared++;
    assert (tmds_word === lastWord) else begin
      nMismatched++;
      $error("FAIL tmds_word: got %b expected %b", tmds_word, lastWord);
    end
`ifdef TMDS_DISP_MON_EN
    nCompared++;
    assert (disp_mon === lastDisp) else begin
      nMismatched++;
      $error("FAIL disp_mon: got %h expected %h", disp_mon, lastDisp);
    end
`endif
  endtask

  // One clock of stimulus: drive, predict, check the word from two steps back, advance.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [8*NUM_CH-1:0] pd,
                               input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] a,
                               input logic rst);
    logic expV;
    reset    = rst;
    in_valid = v;
    mode     = m;
    pix_data = pd;
    ctrl     = c;
    aux_data = a;
    if (v && !rst) pushExpect(m, pd, c, a);
    @(negedge clklow);
    expV  = hist2;
    checkOutput(expV);
    hist2 = hist1;
    hist1 = v && !rst;
    if (rst) begin
      hist1 = 1'b0;
      hist2 = 1'b0;
      sb.delete();
      for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;
      lastWord = RESET_WORDS;
      lastDisp = '0;
    end
    @(posedge clklow);
    #1;
  endtask

  initial begin
    logic [8*NUM_CH-1:0] rp;
    logic [4*NUM_CH-1:0] ra;
    logic [2*NUM_CH-1:0] rc;
    logic [1:0]          rm;
    for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;
    lastWord = RESET_WORDS;
    lastDisp = '0;
    hist1    = 1'b0;
    hist2    = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    mode     = 2'd0;
    pix_data = '0;
    ctrl     = '0;
    aux_data = '0;
    repeat (2) @(posedge clklow);
    #1;

    $display("[TB] control codes after reset");
    applyStimulus(1'b1, 2'd0, '0, 6'b01_10_11, '0, 1'b0);

    $display("[TB] video 0x00 x3 from zero disparity");
    repeat (3) applyStimulus(1'b1, 2'd2, '0, '0, '0, 1'b0);

    $display("[TB] TERC4 sweep then video from cleared counter");
    for (int n = 0; n < 16; n++) applyStimulus(1'b1, 2'd1, '0, '0, {NUM_CH{4'(n)}}, 1'b0);
    applyStimulus(1'b1, 2'd2, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 2'd2, {NUM_CH{8'hA5}}, '0, '0, 1'b0);

    $display("[TB] guard band");
    applyStimulus(1'b1, 2'd3, '0, '0, '0, 1'b0);

    $display("[TB] bubble in a video stream");
    applyStimulus(1'b1, 2'd2, '0, '0, '0, 1'b0);
    applyStimulus(1'b0, 2'd2, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 2'd2, '0, '0, '0, 1'b0);

    $display("[TB] random video with bubbles");
    for (int n = 0; n < 40; n++) begin
      rp = (8*NUM_CH)'({$urandom, $urandom});
      applyStimulus($urandom_range(0, 3) != 0, 2'd2, rp, '0, '0, 1'b0);
    end

    $display("[TB] random mode mix");
    for (int n = 0; n < 40; n++) begin
      rp = (8*NUM_CH)'({$urandom, $urandom});
      ra = (4*NUM_CH)'($urandom);
      rc = (2*NUM_CH)'($urandom);
      rm = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 4) != 0, rm, rp, rc, ra, 1'b0);
    end

    $display("[TB] reset during a video burst, then restart");
    repeat (3) applyStimulus(1'b1, 2'd2, {NUM_CH{8'h3C}}, '0, '0, 1'b0);
    applyStimulus(1'b0, 2'd2, '0, '0, '0, 1'b1);
    applyStimulus(1'b1, 2'd0, '0, 6'b01_10_11, '0, 1'b0);
    repeat (3) applyStimulus(1'b1, 2'd2, '0, '0, '0, 1'b0);

    repeat (3) applyStimulus(1'b0, 2'd0, '0, '0, '0, 1'b0);
    nCompared++;
    assert (sb.size() == 0) else begin
      nMismatched++;
      $error("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
